// File: rtl/result_scoreboard.sv
// Result scoreboard: queues expected results, compares them in order
// against actual results, and keeps per-test pass/fail counts.
module result_scoreboard #(
  parameter int WORD  = 64,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     test_start,
  input  logic                     test_end,
  input  logic                     exp_valid,
  input  logic [WORD-1:0]          exp_data,
  input  logic [7:0]               exp_bits,
  output logic                     exp_ready,
  input  logic                     act_valid,
  input  logic [WORD-1:0]          act_data,
  input  logic [7:0]               act_bits,
  output logic                     act_ready,
  output logic                     res_valid,
  output logic                     res_pass,
  output logic [CW-1:0]            res_step,
  output logic [CW-1:0]            pass_count,
  output logic [CW-1:0]            fail_count,
  output logic [$clog2(DEPTH):0]   unmatched,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX      = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q;
  logic [WORD-1:0] dmem_q [DEPTH];
  logic [7:0]      bmem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW:0]     unm_q;
  logic [CW-1:0]   step_q, pass_q, fail_q, rstep_q;
  logic            rvalid_q, rpass_q;
  logic            run, push, pop, match;

  assign run       = (state_q == RUN);
  assign exp_ready = run && (cnt_q != FULL_CNT);
  assign act_ready = run && (cnt_q != '0);
  assign push      = exp_valid && exp_ready;
  assign pop       = act_valid && act_ready;
  assign match     = (dmem_q[rd_q] == act_data)
                  && (bmem_q[rd_q] == act_bits);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push)
      cnt_d = cnt_q - (AW+1)'(1);
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      dmem_q[wr_q] <= exp_data;
      bmem_q[wr_q] <= exp_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      unm_q    <= '0;
      step_q   <= CW'(1);
      pass_q   <= '0;
      fail_q   <= '0;
      rstep_q  <= '0;
      rvalid_q <= 1'b0;
      rpass_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (test_start) begin
            state_q <= RUN;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            unm_q   <= '0;
            step_q  <= CW'(1);
            pass_q  <= '0;
            fail_q  <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (push)
            wr_q <= wr_q + AW'(1);
          if (pop) begin
            rd_q     <= rd_q + AW'(1);
            rvalid_q <= 1'b1;
            rpass_q  <= match;
            rstep_q  <= step_q;
            if (step_q != MAX)
              step_q <= step_q + CW'(1);
            if (match && pass_q != MAX)
              pass_q <= pass_q + CW'(1);
            if (!match && fail_q != MAX)
              fail_q <= fail_q + CW'(1);
          end
          if (test_end && !test_start) begin
            state_q <= DONE;
            unm_q   <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid  = rvalid_q;
  assign res_pass   = rpass_q;
  assign res_step   = rstep_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign unmatched  = unm_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench for result_scoreboard: vector table plus
// hand sequences for full/wrap, test_end and mid-run reset.
module tb_result_scoreboard;

  logic        clk;
  logic        rst;
  logic        test_start, test_end;
  logic        exp_valid, act_valid;
  logic [63:0] exp_data, act_data;
  logic [7:0]  exp_bits, act_bits;
  logic        exp_ready, act_ready;
  logic        res_valid, res_pass, done;
  logic [15:0] res_step, pass_count, fail_count;
  logic [3:0]  unmatched;

  int total = 0;
  int bad   = 0;

  result_scoreboard #(.WORD(64), .DEPTH(8), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .test_start(test_start), .test_end(test_end),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_bits(exp_bits), .exp_ready(exp_ready),
    .act_valid(act_valid), .act_data(act_data),
    .act_bits(act_bits), .act_ready(act_ready),
    .res_valid(res_valid), .res_pass(res_pass),
    .res_step(res_step), .pass_count(pass_count),
    .fail_count(fail_count), .unmatched(unmatched),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ts, te, ev, av;
    logic [63:0] ed, ad;
    logic [7:0]  eb, ab;
    logic        er, ar, rv, rp, dn;
    logic [15:0] rs, pc, fc;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(
    input logic ts, te, ev,
    input logic [63:0] ed, input logic [7:0] eb,
    input logic av, input logic [63:0] ad, input logic [7:0] ab,
    input logic er, ar, rv, rp,
    input logic [15:0] rs, pc, fc, input logic dn);
    vec_t v;
    v.ts = ts; v.te = te; v.ev = ev; v.ed = ed; v.eb = eb;
    v.av = av; v.ad = ad; v.ab = ab;
    v.er = er; v.ar = ar; v.rv = rv; v.rp = rp;
    v.rs = rs; v.pc = pc; v.fc = fc; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    test_start = 0; test_end = 0;
    exp_valid = 0; exp_data = '0; exp_bits = '0;
    act_valid = 0; act_data = '0; act_bits = '0;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] b);
    exp_valid = 1; exp_data = d; exp_bits = b;
  endtask

  task automatic act(input logic [63:0] d, input logic [7:0] b);
    act_valid = 1; act_data = d; act_bits = b;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".exp_ready"}, 64'(exp_ready), 0);
    chk({tag, ".act_ready"}, 64'(act_ready), 0);
    chk({tag, ".res_valid"}, 64'(res_valid), 0);
    chk({tag, ".res_pass"}, 64'(res_pass), 0);
    chk({tag, ".res_step"}, 64'(res_step), 0);
    chk({tag, ".pass"}, 64'(pass_count), 0);
    chk({tag, ".fail"}, 64'(fail_count), 0);
    chk({tag, ".unmatched"}, 64'(unmatched), 0);
    chk({tag, ".done"}, 64'(done), 0);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    tbl[0]  = mk(0,0,1,5,8,    0,0,0,     1,1,0,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,    1,5,8,     1,0,1,1,1,1,0,0);
    tbl[2]  = mk(0,0,0,0,0,    0,0,0,     1,0,0,0,0,1,0,0);
    tbl[3]  = mk(0,1,0,0,0,    0,0,0,     0,0,0,0,0,1,0,1);
    tbl[4]  = mk(1,0,0,0,0,    0,0,0,     1,0,0,0,0,0,0,0);
    tbl[5]  = mk(0,0,1,7,8,    0,0,0,     1,1,0,0,0,0,0,0);
    tbl[6]  = mk(0,0,0,0,0,    1,7,16,    1,0,1,0,1,0,1,0);
    tbl[7]  = mk(0,0,1,ONES,64,0,0,0,     1,1,0,0,0,0,1,0);
    tbl[8]  = mk(0,0,0,0,0,    1,ONES,64, 1,0,1,1,2,1,1,0);
    tbl[9]  = mk(0,0,0,0,0,    1,0,0,     1,0,0,0,0,1,1,0);
    tbl[10] = mk(0,0,0,0,0,    1,0,0,     1,0,0,0,0,1,1,0);
    tbl[11] = mk(0,0,0,0,0,    1,0,0,     1,0,0,0,0,1,1,0);
    tbl[12] = mk(0,0,1,3,8,    1,3,8,     1,1,0,0,0,1,1,0);
    tbl[13] = mk(0,0,0,0,0,    1,3,8,     1,0,1,1,3,2,1,0);
    tbl[14] = mk(0,0,0,0,0,    0,0,0,     1,0,0,0,0,2,1,0);

    idle_in();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk_reset("rst0");
    cyc();
    chk_reset("idle");

    test_start = 1;
    cyc();
    test_start = 0;
    chk("start.exp_ready", 64'(exp_ready), 1);
    chk("start.act_ready", 64'(act_ready), 0);

    for (int i = 0; i < 15; i++) begin
      test_start = tbl[i].ts; test_end = tbl[i].te;
      exp_valid = tbl[i].ev; exp_data = tbl[i].ed;
      exp_bits = tbl[i].eb;
      act_valid = tbl[i].av; act_data = tbl[i].ad;
      act_bits = tbl[i].ab;
      cyc();
      idle_in();
      chk($sformatf("v%0d.exp_ready", i), 64'(exp_ready), 64'(tbl[i].er));
      chk($sformatf("v%0d.act_ready", i), 64'(act_ready), 64'(tbl[i].ar));
      chk($sformatf("v%0d.res_valid", i), 64'(res_valid), 64'(tbl[i].rv));
      chk($sformatf("v%0d.pass", i), 64'(pass_count), 64'(tbl[i].pc));
      chk($sformatf("v%0d.fail", i), 64'(fail_count), 64'(tbl[i].fc));
      chk($sformatf("v%0d.done", i), 64'(done), 64'(tbl[i].dn));
      if (tbl[i].rv) begin
        chk($sformatf("v%0d.res_pass", i), 64'(res_pass), 64'(tbl[i].rp));
        chk($sformatf("v%0d.res_step", i), 64'(res_step), 64'(tbl[i].rs));
      end
    end

    // Full FIFO, blocked push at full, and pointer wrap.
    test_end = 1; cyc(); idle_in();
    test_start = 1; cyc(); idle_in();
    for (int i = 0; i < 8; i++) begin
      push(64'(100 + i), 8);
      cyc();
      idle_in();
      if (i < 7)
        chk($sformatf("fill%0d.exp_ready", i), 64'(exp_ready), 1);
    end
    chk("full.exp_ready", 64'(exp_ready), 0);
    push(200, 8); act(100, 8);
    cyc(); idle_in();
    chk("fullpop.res_valid", 64'(res_valid), 1);
    chk("fullpop.res_pass", 64'(res_pass), 1);
    chk("fullpop.exp_ready", 64'(exp_ready), 1);
    for (int k = 0; k < 16; k++) begin
      push(64'(108 + k), 8); act(64'(101 + k), 8);
      cyc(); idle_in();
      chk($sformatf("wrap%0d.res_valid", k), 64'(res_valid), 1);
      chk($sformatf("wrap%0d.res_pass", k), 64'(res_pass), 1);
    end
    for (int k = 0; k < 7; k++) begin
      act(64'(117 + k), 8);
      cyc(); idle_in();
      chk($sformatf("drain%0d.res_pass", k), 64'(res_pass), 1);
    end
    chk("drain.act_ready", 64'(act_ready), 0);
    chk("drain.pass", 64'(pass_count), 24);
    chk("drain.fail", 64'(fail_count), 0);
    chk("drain.res_step", 64'(res_step), 24);

    // test_end with a same-cycle pop, then frozen DONE.
    test_end = 1; cyc(); idle_in();
    test_start = 1; cyc(); idle_in();
    for (int i = 0; i < 3; i++) begin
      push(64'(10 + i), 8);
      cyc(); idle_in();
    end
    act(10, 8); test_end = 1;
    cyc(); idle_in();
    chk("end.res_valid", 64'(res_valid), 1);
    chk("end.res_pass", 64'(res_pass), 1);
    chk("end.done", 64'(done), 1);
    chk("end.unmatched", 64'(unmatched), 2);
    chk("end.pass", 64'(pass_count), 1);
    for (int i = 0; i < 3; i++) begin
      push(10, 8); act(11, 8);
      cyc(); idle_in();
      chk($sformatf("frz%0d.res_valid", i), 64'(res_valid), 0);
      chk($sformatf("frz%0d.pass", i), 64'(pass_count), 1);
      chk($sformatf("frz%0d.fail", i), 64'(fail_count), 0);
      chk($sformatf("frz%0d.unmatched", i), 64'(unmatched), 2);
      chk($sformatf("frz%0d.exp_ready", i), 64'(exp_ready), 0);
    end
    test_start = 1; cyc(); idle_in();
    chk("restart.pass", 64'(pass_count), 0);
    chk("restart.fail", 64'(fail_count), 0);
    chk("restart.unmatched", 64'(unmatched), 0);
    chk("restart.done", 64'(done), 0);
    chk("restart.act_ready", 64'(act_ready), 0);
    push(9, 8); cyc(); idle_in();
    act(9, 8); cyc(); idle_in();
    chk("restart.res_step", 64'(res_step), 1);
    chk("restart.res_pass", 64'(res_pass), 1);

    // Reset mid-run with queued entries and a concurrent pop.
    for (int i = 0; i < 4; i++) begin
      push(64'(20 + i), 8);
      cyc(); idle_in();
    end
    act(20, 8); test_start = 1; rst = 1;
    cyc(); idle_in(); rst = 0;
    chk_reset("midrst");
    cyc();
    chk("midrst2.res_valid", 64'(res_valid), 0);
    test_start = 1; cyc(); idle_in();
    chk("postrst.exp_ready", 64'(exp_ready), 1);
    chk("postrst.act_ready", 64'(act_ready), 0);
    push(1, 8); cyc(); idle_in();
    act(1, 8); cyc(); idle_in();
    chk("postrst.res_step", 64'(res_step), 1);
    chk("postrst.pass", 64'(pass_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_scoreboard.md
RESULT_SCOREBOARD -- requirements
Module: result_scoreboard

Interface
REQ-001 Parameters SHALL be:
  - WORD, default 64, data width of compared results.
  - DEPTH, default 8, expected-result FIFO entries (power of two, ≥2).
  - CW, default 16, width of the pass and fail counters.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock; all state updates on its rising edge.
  - rst  in  1  synchronous, active-high reset.
  - test_start  in  1  begin test: clear counters, flush FIFO, enter RUN.
  - test_end  in  1  end test: enter DONE.
  - exp_valid  in  1  expected result offered.
  - exp_data  in  WORD  expected (correct) result.
  - exp_bits  in  8  expected significant-bit count.
  - exp_ready  out  1  expected result accepted when high with exp_valid.
  - act_valid  in  1  actual (DUT) result offered.
  - act_data  in  WORD  actual result.
  - act_bits  in  8  actual significant-bit count.
  - act_ready  out  1  actual result accepted when high with act_valid.
  - res_valid  out  1  one-cycle comparison-result pulse.
  - res_pass  out  1  comparison passed; qualified by res_valid.
  - res_step  out  CW  step number of the reported comparison.
  - pass_count  out  CW  passes this test.
  - fail_count  out  CW  fails this test.
  - unmatched  out  $clog2(DEPTH)+1  expected entries left when DONE was entered.
  - done  out  1  high while in DONE.

Function
REQ-003 The block SHALL have three states, IDLE, RUN and DONE, with transitions:
  - IDLE→RUN on test_start.
  - RUN→DONE on test_end.
  - DONE→RUN on test_start.
  - All other cases: hold.
REQ-004 test_start SHALL take priority over test_end when both are high in the same cycle.
REQ-005 Entering RUN SHALL:
  - clear pass_count and fail_count;
  - set the step counter to 1;
  - empty the FIFO;
  - clear unmatched.
REQ-006 exp_ready SHALL equal (state==RUN and FIFO not full), decoded from registered state only.
REQ-007 act_ready SHALL equal (state==RUN and FIFO not empty), decoded from registered state only.
REQ-008 A push SHALL occur when exp_valid and exp_ready are both high; exp_data and exp_bits are written at the tail.
REQ-009 A pop-and-compare SHALL occur when act_valid and act_ready are both high; the head entry is compared with act_data and act_bits.
REQ-010 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-011 Pointers SHALL wrap modulo DEPTH.
REQ-012 An empty FIFO SHALL never bypass an expected value to a same-cycle actual value; act_ready is 0 in that cycle.
REQ-013 Pass SHALL be defined as (exp_data==act_data) and (exp_bits==act_bits), exact bitwise equality.
REQ-014 Comparison latency SHALL be one cycle: res_valid, res_pass and res_step are registered and appear the cycle after the pop.
REQ-015 res_step SHALL carry the step value current at the pop; the step counter then increments by 1.
REQ-016 pass_count or fail_count SHALL increment in the same edge that registers res_valid.
REQ-017 pass_count, fail_count and step SHALL saturate at 2^CW−1 and not wrap.
REQ-018 On RUN→DONE, unmatched SHALL capture FIFO occupancy after any same-cycle push or pop.
REQ-019 A comparison popped in the test_end cycle SHALL still be reported and counted.
REQ-020 In IDLE and DONE, pass_count, fail_count, unmatched and the FIFO contents SHALL be frozen.
REQ-021 done SHALL be high exactly while the state is DONE.
REQ-022 res_valid SHALL be 0 at all times other than the single pulse defined in REQ-014.

Reset
REQ-023 rst SHALL be sampled only at the rising clk edge and SHALL override all other inputs, including test_start.
REQ-024 After reset the block SHALL be:
  - state IDLE; FIFO empty; step 1;
  - exp_ready, act_ready, res_valid, res_pass, done = 0;
  - res_step, pass_count, fail_count, unmatched = 0.
REQ-025 Reset asserted mid-RUN SHALL discard FIFO contents and any pending comparison; no res_valid pulse follows the reset edge.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Reset, test_start, push (5,8), then actual (5,8) → one cycle later res_valid=1, res_pass=1, res_step=1, pass_count=1.
  - Push (7,8); actual (7,16) → res_pass=0, fail_count=1, res_step=1; then push and match (−1,64) → res_step=2, pass_count=1.
  - DEPTH=8: push 8 entries → exp_ready=0 on the cycle after the 8th push; simultaneous push+pop at full is impossible (exp_ready=0); pop one → exp_ready=1; 16 interleaved entries all pass, demonstrating pointer wrap.
  - FIFO empty, act_valid=1 held 3 cycles → act_ready=0 and no res_valid; push (3,8) → act_ready=1 next cycle and res_pass=1.
  - Push 3 entries, match 1, assert test_end → done=1, unmatched=2, counters frozen under further stimulus; test_start → counters 0, step 1, unmatched 0.
  - rst asserted during RUN with 4 entries queued and a pop in the same cycle → all outputs at reset values, no res_valid pulse, FIFO empty after test_start.
